// File: rtl/fill_ram_pkg.sv
// Shared constants and state types for the RAM fill engine and the read-back checker.
package fill_ram_pkg;

    localparam int RAM_SIZE   = 1048576;
    localparam int BLOCK_SIZE = 4096;
    localparam int DW_DEFAULT = 512;
    localparam int BEATS      = BLOCK_SIZE / (DW_DEFAULT / 8);
    localparam int NBLK       = RAM_SIZE / BLOCK_SIZE;
    localparam logic [31:0] FIRST_DATA = 32'hC000_0000;

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [1:0] RESP_OKAY  = 2'd0;

    typedef enum logic [1:0] {
        AR_IDLE,
        AR_RUN,
        AR_FINISH
    } ar_state_e;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } r_state_e;

endpackage

// File: rtl/axi_burst_tracker.sv
// Counts read bursts in flight; can_issue_o reflects the count after this cycle's updates.
module axi_burst_tracker
    import fill_ram_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ar_hs_i,
    input  logic r_last_hs_i,
    output logic can_issue_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ar_hs_i && !r_last_hs_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!ar_hs_i && r_last_hs_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign can_issue_o = (cnt_d < CW'(MAX_OUTSTANDING));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/check_ram.sv
// AXI4 read master that streams back the filled RAM region and checks the incrementing pattern.
// Define CHECK_RRESP_EN to also flag any non-OKAY read response as an error beat.
module check_ram #(
    parameter int          DW              = 512,
    parameter int          AW              = 20,
    parameter logic [31:0] FIRST_DATA      = fill_ram_pkg::FIRST_DATA,
    parameter int          RAM_SIZE        = fill_ram_pkg::RAM_SIZE,
    parameter int          BLOCK_SIZE      = fill_ram_pkg::BLOCK_SIZE,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [31:0]   error_count,
    output logic [AW-1:0] first_error_addr,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [3:0]    M_AXI_ARID,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    output logic          M_AXI_ARLOCK,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic          M_AXI_RVALID,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    output logic          M_AXI_RREADY
);
    import fill_ram_pkg::*;

    localparam int BYTES   = DW / 8;
    localparam int N_BEATS = BLOCK_SIZE / BYTES;
    localparam int N_BLK   = RAM_SIZE / BLOCK_SIZE;
    localparam int BEAT_W  = $clog2(N_BEATS);
    localparam int BLK_W   = (N_BLK > 1) ? $clog2(N_BLK) : 1;
    localparam int ARCNT_W = $clog2(N_BLK + 1);
    localparam int SZ_SH   = $clog2(BYTES);
    localparam int BLK_SH  = $clog2(BLOCK_SIZE);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    ar_state_e            ar_state_q;
    logic                 arvalid_q;
    logic [AW-1:0]        araddr_q;
    logic [ARCNT_W-1:0]   ar_cnt_q;

    r_state_e             r_state_q;
    logic                 rready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [31:0]          err_cnt_q;
    logic [AW-1:0]        first_err_q;
    logic [DW-1:0]        exp_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [BLK_W-1:0]     blk_q;

    logic start_acc, ar_hs, last_ar, can_issue;
    logic r_hs, r_last_hs, beat_last, final_beat, beat_err;
    logic [AW-1:0] err_addr;

    assign start_acc  = start && (ar_state_q == AR_IDLE) && (r_state_q == R_IDLE);
    assign ar_hs      = arvalid_q && M_AXI_ARREADY;
    assign last_ar    = (ar_cnt_q == ARCNT_W'(N_BLK - 1));
    assign r_hs       = M_AXI_RVALID && rready_q;
    assign r_last_hs  = r_hs && M_AXI_RLAST;
    assign beat_last  = (beat_q == BEAT_W'(N_BEATS - 1));
    assign final_beat = beat_last && (blk_q == BLK_W'(N_BLK - 1));
    assign err_addr   = (AW'(blk_q) << BLK_SH) | (AW'(beat_q) << SZ_SH);

    always_comb begin
        beat_err = (M_AXI_RDATA != exp_q) || (M_AXI_RLAST != beat_last);
`ifdef CHECK_RRESP_EN
        beat_err = beat_err || (M_AXI_RRESP != RESP_OKAY);
`endif
    end

`ifndef CHECK_RRESP_EN
    logic unused_rresp;
    assign unused_rresp = ^M_AXI_RRESP;
`endif

    axi_burst_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CW              (OUT_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .ar_hs_i     (ar_hs),
        .r_last_hs_i (r_last_hs),
        .can_issue_o (can_issue)
    );

    // Address channel: one INCR burst per block, throttled by the in-flight limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            ar_cnt_q   <= '0;
        end else begin
            case (ar_state_q)
                AR_IDLE: begin
                    if (start_acc) begin
                        araddr_q   <= '0;
                        ar_cnt_q   <= '0;
                        arvalid_q  <= 1'b1;
                        ar_state_q <= AR_RUN;
                    end
                end
                AR_RUN: begin
                    if (ar_hs) begin
                        araddr_q <= araddr_q + AW'(BLOCK_SIZE);
                        ar_cnt_q <= ar_cnt_q + 1'b1;
                        if (last_ar) begin
                            arvalid_q  <= 1'b0;
                            ar_state_q <= AR_FINISH;
                        end else begin
                            arvalid_q <= can_issue;
                        end
                    end else if (!arvalid_q) begin
                        arvalid_q <= can_issue;
                    end
                end
                AR_FINISH: begin
                    if (r_hs && final_beat) begin
                        ar_state_q <= AR_IDLE;
                    end
                end
                default: ar_state_q <= AR_IDLE;
            endcase
        end
    end

    // Data channel: beat/block position is counted by handshakes, independent of RLAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            exp_q       <= '0;
            beat_q      <= '0;
            blk_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (r_state_q)
                R_IDLE: begin
                    if (start_acc) begin
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        pass_q      <= 1'b0;
                        exp_q       <= DW'(FIRST_DATA);
                        beat_q      <= '0;
                        blk_q       <= '0;
                        rready_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        r_state_q   <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (r_hs) begin
                        exp_q  <= exp_q + 1'b1;
                        beat_q <= beat_last ? '0 : beat_q + 1'b1;
                        if (beat_last) begin
                            blk_q <= blk_q + 1'b1;
                        end
                        if (beat_err) begin
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            if (err_cnt_q == '0) begin
                                first_err_q <= err_addr;
                            end
                        end
                        if (final_beat) begin
                            rready_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            pass_q    <= (err_cnt_q == '0) && !beat_err;
                            r_state_q <= R_IDLE;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign error_count      = err_cnt_q;
    assign first_error_addr = first_err_q;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARLEN   = 8'(N_BEATS - 1);
    assign M_AXI_ARSIZE  = 3'(SZ_SH);
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARID    = 4'd0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_check_ram.sv
// Bench for check_ram: an AXI read slave serving the fill pattern with injected faults,
// scored against a beat-index model of the expected pattern.
module tb_check_ram;
    localparam int DW    = 512;
    localparam int AW    = 20;
    localparam int BEATS = 64;
    localparam int NBLK  = 256;
    localparam int TOTAL = BEATS * NBLK;
    localparam logic [31:0] FD = 32'hC000_0000;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, done, pass;
    logic [31:0] error_count;
    logic [AW-1:0] first_error_addr, araddr;
    logic arvalid, arready, arlock, rvalid, rlast, rready;
    logic [7:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, rresp;
    logic [3:0] arid, arcache, arqos;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    check_ram dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_error_addr(first_error_addr),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARID(arid), .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos),
        .M_AXI_ARPROT(arprot), .M_AXI_ARLOCK(arlock),
        .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RRESP(rresp),
        .M_AXI_RLAST(rlast), .M_AXI_RREADY(rready)
    );

    typedef struct {
        int ar_pct;
        int rv_pct;
        int stall;
        int corrupt;
        int early;
        int bad_resp;
        int abort_at;
        int exp_errs;
        int exp_first;
        bit exp_pass;
    } scen_t;

    scen_t tbl[4];
    scen_t cfg;

    int checks = 0;
    int errors = 0;
    int ar_pct, rv_pct;
    int ar_seen, beats_sent, pending, outstanding, max_out;
    int ar_bad, ar_unstable, done_cnt, step_no, last_hs_step, done_step;
    int m_errs, m_first;
    bit prev_wait;
    logic [AW-1:0] prev_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int idx);
        return DW'(FD) + DW'(idx);
    endfunction

    // Spec-level scoring of one accepted beat by its global index in the pass.
    task automatic score(input int idx);
        bit bad;
        bad = (rdata != pattern(idx)) || (rlast != ((idx % BEATS) == BEATS - 1));
`ifdef CHECK_RRESP_EN
        bad = bad || (rresp != 2'd0);
`endif
        if (bad) begin
            if (m_errs == 0) m_first = idx * (DW / 8);
            m_errs++;
        end
    endtask

    // One clock of slave behaviour; inputs change on the falling edge.
    task automatic step();
        bit hs_ar, hs_r;
        int idx;
        @(negedge clk);
        step_no++;
        if (done === 1'b1) begin
            done_cnt++;
            if (done_cnt == 1) done_step = step_no;
        end
        if (prev_wait && (arvalid !== 1'b1 || araddr !== prev_addr)) ar_unstable++;
        arready = ($urandom_range(0, 99) < ar_pct);
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'd0;
        rdata = '0;
        idx = beats_sent;
        if (pending > 0 && $urandom_range(0, 99) < rv_pct) begin
            rvalid = 1'b1;
            rdata = (idx == cfg.corrupt) ? '0 : pattern(idx);
            rlast = ((idx % BEATS) == BEATS - 1);
            if (idx == cfg.early) rlast = 1'b1;
            else if (cfg.early >= 0 && idx == cfg.early + 1) rlast = 1'b0;
            if (idx == cfg.bad_resp) rresp = 2'd2;
        end
        hs_ar = (arvalid === 1'b1) && arready;
        hs_r = rvalid && (rready === 1'b1);
        if (hs_r) begin
            score(idx);
            beats_sent++;
            if (beats_sent % BEATS == 0) pending--;
            if (rlast) outstanding--;
            if (beats_sent == TOTAL) last_hs_step = step_no;
        end
        if (hs_ar) begin
            if (araddr !== AW'(ar_seen * 4096)) ar_bad++;
            ar_seen++;
            pending++;
            outstanding++;
        end
        if (outstanding > max_out) max_out = outstanding;
        prev_wait = (arvalid === 1'b1) && !arready;
        prev_addr = araddr;
    endtask

    initial begin
        tbl[0] = '{100, 100, 0, -1, -1, -1, -1, 0, 0, 1'b1};
        tbl[1] = '{100, 100, 0, 65, -1, -1, -1, 1, 'h1040, 1'b0};
        tbl[2] = '{100, 100, 0, -1, 62, -1, 150, 2, 'h0F80, 1'b0};
`ifdef CHECK_RRESP_EN
        tbl[3] = '{60, 70, 200, -1, -1, 300, -1, 1, 300 * 64, 1'b0};
`else
        tbl[3] = '{60, 70, 200, -1, -1, 300, -1, 0, 0, 1'b1};
`endif

        reset = 1'b1;
        start = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        rresp = 2'd0;
        rlast = 1'b0;
        ar_pct = 0;
        rv_pct = 0;
        cfg = tbl[0];
        repeat (3) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", error_count, 0);
        chk("rst_first", first_error_addr, 0);
        chk("rst_araddr", araddr, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_arvalid", arvalid, 0);
        chk("arlen", arlen, 63);
        chk("arsize", arsize, 6);
        chk("arburst", arburst, 1);
        chk("ar_misc", {arid, arcache, arqos, arprot, arlock}, 0);

        for (int s = 0; s < 4; s++) begin
            int n;
            string p;
            p = $sformatf("s%0d_", s);
            cfg = tbl[s];
            ar_pct = cfg.ar_pct;
            rv_pct = (cfg.stall > 0) ? 0 : cfg.rv_pct;
            ar_seen = 0; beats_sent = 0; pending = 0; outstanding = 0; max_out = 0;
            ar_bad = 0; ar_unstable = 0; done_cnt = 0; step_no = 0;
            last_hs_step = -100; done_step = -1; m_errs = 0; m_first = 0; prev_wait = 1'b0;

            start = 1'b1;
            step();
            start = 1'b0;
            chk({p, "busy_on"}, busy, 1);
            chk({p, "arvalid_lat"}, arvalid, 1);
            chk({p, "rready_on"}, rready, 1);
            chk({p, "err_clr"}, error_count, 0);
            chk({p, "pass_clr"}, pass, 0);

            n = 0;
            while (done_cnt == 0 && n < 40000 && !(cfg.abort_at >= 0 && beats_sent >= cfg.abort_at)) begin
                if (s == 0 && n == 100) start = 1'b1;
                step();
                start = 1'b0;
                n++;
                if (cfg.stall > 0 && n == cfg.stall) begin
                    chk({p, "stall_ar_count"}, ar_seen, 4);
                    chk({p, "stall_arvalid"}, arvalid, 0);
                    rv_pct = cfg.rv_pct;
                end
            end

            if (cfg.abort_at < 0) begin
                chk({p, "done_latency"}, done_step - last_hs_step, 1);
                chk({p, "busy_off"}, busy, 0);
                chk({p, "pass"}, pass, cfg.exp_pass);
                chk({p, "pass_model"}, pass, (m_errs == 0));
                chk({p, "err"}, error_count, cfg.exp_errs);
                chk({p, "err_model"}, error_count, m_errs);
                chk({p, "first"}, first_error_addr, cfg.exp_first);
                chk({p, "first_model"}, first_error_addr, m_first);
                repeat (5) step();
                chk({p, "done_pulses"}, done_cnt, 1);
                chk({p, "pass_hold"}, pass, cfg.exp_pass);
                chk({p, "ar_count"}, ar_seen, NBLK);
                chk({p, "beats"}, beats_sent, TOTAL);
                chk({p, "ar_addr_bad"}, ar_bad, 0);
                chk({p, "ar_unstable"}, ar_unstable, 0);
                chk({p, "outstanding_le4"}, (max_out <= 4), 1);
                chk({p, "outstanding_hit4"}, (max_out == 4 || cfg.rv_pct == 100), 1);
                chk({p, "arvalid_end"}, arvalid, 0);
                chk({p, "rready_end"}, rready, 0);
            end else begin
                int seen;
                chk({p, "abort_err"}, error_count, cfg.exp_errs);
                chk({p, "abort_err_model"}, error_count, m_errs);
                chk({p, "abort_first"}, first_error_addr, cfg.exp_first);
                chk({p, "abort_first_model"}, first_error_addr, m_first);
                chk({p, "abort_busy"}, busy, 1);
                reset = 1'b1;
                arready = 1'b0;
                rvalid = 1'b0;
                #1;
                chk({p, "rst_arvalid_now"}, arvalid, 0);
                chk({p, "rst_rready_now"}, rready, 0);
                chk({p, "rst_busy_now"}, busy, 0);
                chk({p, "rst_err_now"}, error_count, 0);
                repeat (3) @(negedge clk);
                reset = 1'b0;
                seen = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (arvalid === 1'b1 || busy === 1'b1) seen++;
                end
                chk({p, "quiet_after_reset"}, seen, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/check_ram.md
Name: check_ram

Overview:
- AXI4 read master that reads back the 1 MiB RAM region written by the RAM-fill engine and verifies the incrementing data pattern.
- Issues INCR bursts of one 4 KiB block each and compares every returned beat against the expected value.
- Reports pass/fail, an error count and the first failing byte address.
- Sits beside the fill engine on the same AXI interconnect port; used for memory bring-up and self-test.

Parameters:
- DW, 512, AXI data width in bits; power of two, 32..1024.
- AW, 20, AXI address width in bits.
- FIRST_DATA, 32'hC000_0000, expected value of beat 0, zero-extended to DW.
- RAM_SIZE, 1048576, bytes checked.
- BLOCK_SIZE, 4096, bytes per burst.
- MAX_OUTSTANDING, 4, maximum bursts in flight (1..15).

Ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle pulse; begins a check pass when idle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse when the final beat is accepted.
- pass  output  1  valid from done until the next start; 1 = zero errors.
- error_count  output  32  number of mismatching beats; saturates at 32'hFFFF_FFFF.
- first_error_addr  output  AW  byte address of the first mismatching beat.
- M_AXI_ARADDR  output  AW  burst address.
- M_AXI_ARVALID  output  1  read address valid.
- M_AXI_ARREADY  input  1  read address ready.
- M_AXI_ARLEN  output  8  constant BLOCK_SIZE/(DW/8)-1.
- M_AXI_ARSIZE  output  3  constant $clog2(DW/8).
- M_AXI_ARBURST  output  2  constant 1 (INCR).
- M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS  output  4 each  constant 0.
- M_AXI_ARPROT  output  3  constant 0.
- M_AXI_ARLOCK  output  1  constant 0.
- M_AXI_RDATA  input  DW  read data.
- M_AXI_RVALID  input  1  read data valid.
- M_AXI_RRESP  input  2  read response.
- M_AXI_RLAST  input  1  last beat of a burst.
- M_AXI_RREADY  output  1  read data ready.

Behaviour:
- Derived values:
  - BEATS = BLOCK_SIZE/(DW/8); 64 at defaults.
  - NBLK = RAM_SIZE/BLOCK_SIZE; 256 at defaults.
- Reset values (async): ARVALID=0, RREADY=0, busy=0, done=0, pass=0, error_count=0, first_error_addr=0, ARADDR=0, both FSMs IDLE, outstanding=0.
- Reset mid-pass aborts immediately; no further AR is issued.
- start while busy is ignored.
- Accepted start (IDLE only), applied on the next clock edge:
  - error_count, first_error_addr and pass cleared.
  - Expected data = FIRST_DATA.
  - ARADDR = 0.
  - busy = 1 and RREADY = 1.
  - Both FSMs move to RUN.
- AR FSM, states IDLE, RUN, FINISH:
  - ARVALID rises only when outstanding < MAX_OUTSTANDING and blocks remain.
  - Once raised, ARVALID stays high until ARREADY; ARADDR is stable while ARVALID is high.
  - On handshake: ARADDR += BLOCK_SIZE. If NBLK bursts have been issued, go to FINISH with ARVALID=0. Otherwise ARVALID is re-evaluated for the next cycle against outstanding after this cycle's update.
  - FINISH returns to IDLE when done fires.
- outstanding counter:
  - +1 on an AR handshake; -1 on an R handshake with RLAST.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- R FSM, states IDLE, RUN:
  - Each R handshake (RVALID & RREADY) compares RDATA with expected data.
  - Expected data increments by 1 (DW-bit wrap) on every handshake.
  - beat runs 0..BEATS-1; block runs 0..NBLK-1.
  - A beat is an error if RDATA != expected, or RLAST != (beat==BEATS-1).
  - Each error beat increments error_count (saturating).
  - On the first error of a pass, first_error_addr = block*BLOCK_SIZE + beat*(DW/8).
  - RVALID with RREADY low is impossible outside RUN; RREADY=0 in IDLE.
- Completion, on the handshake of beat BEATS-1 of block NBLK-1:
  - RREADY=0, busy=0, done=1 for one cycle.
  - pass = 1 if no error occurred, including an error on this same beat.
  - Both FSMs return to IDLE.
- Latency: first ARVALID 1 cycle after start; done 1 cycle after the final R handshake.

Optional Feature:
- CHECK_RRESP_EN:
  - Defined: an R handshake with RRESP != 0 is also an error beat. It counts once even if the data also mismatches.
  - Undefined: RRESP is ignored.

Decomposition:
- Package fill_ram_pkg:
  - Shared localparams: RAM_SIZE, BLOCK_SIZE, BEATS, NBLK, FIRST_DATA default.
  - AXI constants: BURST_INCR=2'd1, RESP_OKAY=2'd0.
  - The fill engine and the checker both use it.
- Sub-module axi_burst_tracker: outstanding up/down counter with limit compare, producing can_issue.

Test Plan:
- Memory model holding the correct pattern, ARREADY/RVALID always 1, start → 256 ARs at 0x00000..0xFF000 with ARLEN=63, ARSIZE=6, 16384 beats, done pulse, pass=1, error_count=0.
- Beat at 0x01040 corrupted to 0 → error_count=1, first_error_addr=0x01040, pass=0.
- ARREADY=1, RVALID held 0 for 200 cycles → exactly 4 ARs issued, then the AR channel stalls until the first RLAST. Random RVALID/ARREADY backpressure → same result as scenario 1, outstanding never >4.
- RLAST asserted on beat 62 of block 0 (correct data) → error_count=2 (beat 62 and beat 63), first_error_addr=0x00F80.
- start pulsed again at cycle 100 of a pass → ignored. reset asserted mid-pass → ARVALID, RREADY and busy drop immediately; a new start after reset gives a clean pass.
- RRESP=2 on one beat with correct data → error_count=1 with CHECK_RRESP_EN; pass=1 without it.
